// File: rtl/pc_next_unit_pkg.sv
//------------------------------------------------------------------------------
// pc_next_unit_pkg : shared processor constants for next-PC formation
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pc_next_unit_pkg;

   localparam int c_DATA_W_DEF  = 8;
   localparam int c_JMP_W_DEF   = 5;
   localparam int c_IMM_W_DEF   = 5;
   localparam int c_PC_STEP_DEF = 1;

   localparam int c_JMP_MODE_ZERO = 0;
   localparam int c_JMP_MODE_PAGE = 1;

   typedef enum logic [0:0] {
      EXT_ZERO = 1'b0,
      EXT_SIGN = 1'b1
   } ext_mode_e;

endpackage

`default_nettype wire

// File: rtl/pc_next_unit_imm_extend.sv
//------------------------------------------------------------------------------
// imm_extend : zero/sign extension of a field to a wider target width
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imm_extend
   import pc_next_unit_pkg::*;
#(
   parameter int        IN_W  = 5,
   parameter int        OUT_W = 8,
   parameter ext_mode_e MODE  = EXT_ZERO
) (
   input  logic [IN_W-1:0]  i_val,
   output logic [OUT_W-1:0] o_val
);

   generate
      if (OUT_W <= IN_W) begin : g_same
         assign o_val = i_val[OUT_W-1:0];
      end else if (MODE == EXT_SIGN) begin : g_sign
         assign o_val = {{(OUT_W-IN_W){i_val[IN_W-1]}}, i_val};
      end else begin : g_zero
         assign o_val = {{(OUT_W-IN_W){1'b0}}, i_val};
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/pc_next_unit.sv
//------------------------------------------------------------------------------
// pc_next_unit : program counter with jump/branch redirect and stall-pending
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_next_unit
   import pc_next_unit_pkg::*;
#(
   parameter int DATA_W   = c_DATA_W_DEF,
   parameter int JMP_W    = c_JMP_W_DEF,
   parameter int IMM_W    = c_IMM_W_DEF,
   parameter int PC_STEP  = c_PC_STEP_DEF,
   parameter int JMP_MODE = c_JMP_MODE_ZERO
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              jump,
   input  logic [JMP_W-1:0]  jaddr,
   input  logic              branch,
   input  logic [IMM_W-1:0]  imm,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] pc_seq,
   output logic              pending,
   output logic              flush
);

   // Low JMP_W bits come from jaddr in page mode; the rest from pc_seq.
   localparam logic [DATA_W-1:0] c_JMASK = ~({DATA_W{1'b1}} << JMP_W);

   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_held;
   logic              r_pending;
   logic              r_flush;

   logic [DATA_W-1:0] w_pc_seq;
   logic [DATA_W-1:0] w_jaddr_ext;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_jtgt;
   logic [DATA_W-1:0] w_btgt;
   logic [DATA_W-1:0] w_req_tgt;
   logic [DATA_W-1:0] w_pc_next;
   logic              w_req;

   assign w_pc_seq = r_pc + DATA_W'(PC_STEP);

   imm_extend #(.IN_W(JMP_W), .OUT_W(DATA_W), .MODE(EXT_ZERO)) u_jext (
      .i_val (jaddr),
      .o_val (w_jaddr_ext)
   );

   imm_extend #(.IN_W(IMM_W), .OUT_W(DATA_W), .MODE(EXT_SIGN)) u_bext (
      .i_val (imm),
      .o_val (w_imm_ext)
   );

   generate
      if (JMP_MODE == c_JMP_MODE_PAGE) begin : g_jmp_page
         assign w_jtgt = (w_jaddr_ext & c_JMASK) | (w_pc_seq & ~c_JMASK);
      end else begin : g_jmp_zero
         assign w_jtgt = w_jaddr_ext;
      end
   endgenerate

   assign w_btgt    = w_pc_seq + w_imm_ext;
   assign w_req     = jump | branch;
   assign w_req_tgt = jump ? w_jtgt : w_btgt;

   // A fresh request beats a held one; otherwise fall through to sequential.
   always_comb begin
      w_pc_next = w_pc_seq;
      if (w_req) begin
         w_pc_next = w_req_tgt;
      end else if (r_pending) begin
         w_pc_next = r_held;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc      <= '0;
         r_held    <= '0;
         r_pending <= 1'b0;
         r_flush   <= 1'b0;
      end else begin
         if (en) begin
            r_pc      <= w_pc_next;
            r_pending <= 1'b0;
         end else if (w_req) begin
            r_pending <= 1'b1;
            r_held    <= w_req_tgt;
         end
         r_flush <= en & (w_req | r_pending);
      end
   end

   assign pc      = r_pc;
   assign pc_seq  = w_pc_seq;
   assign pending = r_pending;
   assign flush   = r_flush;

endmodule

`default_nettype wire

// File: tb/tb_pc_next_unit.sv
//------------------------------------------------------------------------------
// tb_pc_next_unit : directed self-checking bench for pc_next_unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_next_unit;

   logic       clk = 1'b0;
   logic       reset, en, jump, branch;
   logic [4:0] jaddr, imm;

   logic [7:0] pc, pc_seq;
   logic       pending, flush;
   logic [7:0] pc2, pc_seq2;
   logic       pending2, flush2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_next_unit #(.DATA_W(8), .JMP_W(5), .IMM_W(5), .PC_STEP(1), .JMP_MODE(0)) dut (
      .clk(clk), .reset(reset), .en(en), .jump(jump), .jaddr(jaddr),
      .branch(branch), .imm(imm), .pc(pc), .pc_seq(pc_seq),
      .pending(pending), .flush(flush)
   );

   pc_next_unit #(.DATA_W(8), .JMP_W(5), .IMM_W(5), .PC_STEP(1), .JMP_MODE(1)) dut_page (
      .clk(clk), .reset(reset), .en(en), .jump(jump), .jaddr(jaddr),
      .branch(branch), .imm(imm), .pc(pc2), .pc_seq(pc_seq2),
      .pending(pending2), .flush(flush2)
   );

   task automatic cyc(input logic r, input logic e, input logic j, input logic [4:0] ja,
                      input logic b, input logic [4:0] im);
      reset = r; en = e; jump = j; jaddr = ja; branch = b; imm = im;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("reset_pc", pc, 8'h00);
      chk("reset_pending", pending, 1'b0);
      chk("reset_flush", flush, 1'b0);

      cyc(0, 1, 0, 0, 0, 0); chk("seq1", pc, 8'h01); chk("seq1_flush", flush, 1'b0);
      cyc(0, 1, 0, 0, 0, 0); chk("seq2", pc, 8'h02);
      cyc(0, 1, 0, 0, 0, 0); chk("seq3", pc, 8'h03); chk("seq3_flush", flush, 1'b0);

      // jump zero-extended
      cyc(0, 1, 1, 5'h10, 0, 0); chk("jmp_to_10", pc, 8'h10);
      cyc(0, 1, 1, 5'h1F, 0, 0); chk("jmp_1F", pc, 8'h1F); chk("jmp_flush", flush, 1'b1);
      cyc(0, 0, 0, 0, 0, 0); chk("jmp_flush_drop", flush, 1'b0); chk("stall_hold", pc, 8'h1F);

      // backward branch, then jump beats branch
      cyc(0, 1, 1, 5'h10, 0, 0);
      cyc(0, 1, 0, 0, 1, 5'h1E); chk("br_neg2", pc, 8'h0F);
      cyc(0, 1, 1, 5'h10, 0, 0);
      cyc(0, 1, 1, 5'h03, 1, 5'h1E); chk("jmp_over_br", pc, 8'h03);

      // reach 0x20, then branch while stalled
      cyc(0, 1, 1, 5'h1F, 0, 0);
      cyc(0, 1, 0, 0, 1, 5'h00); chk("br_to_20", pc, 8'h20);
      cyc(0, 0, 0, 0, 1, 5'h04);
      chk("stall_br_pc", pc, 8'h20); chk("stall_br_pending", pending, 1'b1);
      chk("stall_br_flush", flush, 1'b0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("pend_apply_pc", pc, 8'h25); chk("pend_apply_clear", pending, 1'b0);
      chk("pend_apply_flush", flush, 1'b1); chk("pc_seq_26", pc_seq, 8'h26);

      // newest held request wins
      cyc(0, 0, 0, 0, 1, 5'h01); chk("pend_first", pending, 1'b1);
      cyc(0, 0, 1, 5'h07, 0, 0);
      cyc(0, 1, 0, 0, 0, 0); chk("pend_newest", pc, 8'h07);
      // fresh request beats held target
      cyc(0, 0, 1, 5'h09, 0, 0);
      cyc(0, 1, 0, 0, 1, 5'h02); chk("fresh_over_held", pc, 8'h0A);
      chk("fresh_flush", flush, 1'b1);

      // wrap 0xFF -> 0x00
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1, 5'h1E); chk("br_to_FF", pc, 8'hFF); chk("pc_seq_wrap", pc_seq, 8'h00);
      cyc(0, 1, 0, 0, 0, 0); chk("pc_wrap", pc, 8'h00);

      // page-mode jump on the second instance
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1, 5'h10); chk("page_br1", pc2, 8'hF1);
      cyc(0, 1, 0, 0, 1, 5'h10); chk("page_br2", pc2, 8'hE2);
      cyc(0, 1, 0, 0, 1, 5'h1D); chk("page_E0", pc2, 8'hE0);
      cyc(0, 1, 1, 5'h03, 0, 0); chk("page_jmp", pc2, 8'hE3); chk("page_flush", flush2, 1'b1);

      // reset during a held redirect
      cyc(0, 0, 1, 5'h05, 0, 0); chk("pre_rst_pending", pending, 1'b1);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_pend_pc", pc, 8'h00); chk("rst_pend_clear", pending, 1'b0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("post_rst_pc", pc, 8'h01); chk("post_rst_flush", flush, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: PC and target width.
REQ-002 The block SHALL have parameter JMP_W, default 5: jump-field width, legal range 1..DATA_W.
REQ-003 The block SHALL have parameter IMM_W, default 5: branch-offset width, legal range 1..DATA_W.
REQ-004 The block SHALL have parameter PC_STEP, default 1: sequential increment.
REQ-005 The block SHALL have parameter JMP_MODE, default 0: 0 = zero-extend jaddr to DATA_W; 1 = {pc_seq upper bits, jaddr}.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port en, input, 1 bit: 1 = advance PC; 0 = stall.
REQ-009 The block SHALL have port jump, input, 1 bit: jump redirect request.
REQ-010 The block SHALL have port jaddr, input, JMP_W bits: jump field.
REQ-011 The block SHALL have port branch, input, 1 bit: taken-branch redirect request.
REQ-012 The block SHALL have port imm, input, IMM_W bits: signed branch offset.
REQ-013 The block SHALL have port pc, output, DATA_W bits: current PC (registered).
REQ-014 The block SHALL have port pc_seq, output, DATA_W bits: pc + PC_STEP (combinational from pc).
REQ-015 The block SHALL have port pending, output, 1 bit: a redirect is held awaiting en.
REQ-016 The block SHALL have port flush, output, 1 bit: one-cycle pulse, 1 in the cycle after a redirect was applied to pc.

Function
REQ-017 The block SHALL compute jump target as zero-extension of jaddr to DATA_W when JMP_MODE=0, and as {pc_seq[DATA_W-1:JMP_W], jaddr} when JMP_MODE=1 (JMP_W=DATA_W gives jaddr).
REQ-018 The block SHALL compute branch target as pc_seq + sign-extend(imm) to DATA_W, modulo 2^DATA_W (wrap, no overflow flag).
REQ-019 pc_seq SHALL wrap modulo 2^DATA_W (255 + 1 = 0 at DATA_W=8).
REQ-020 When jump and branch are both 1 in the same cycle, jump SHALL win and branch SHALL be discarded.
REQ-021 With en=1 and no pending redirect, the next pc SHALL be: jump target if jump, else branch target if branch, else pc_seq.
REQ-022 With en=0, pc SHALL hold; a jump/branch request that cycle SHALL be captured as a target into a one-entry pending register and pending SHALL rise next cycle.
REQ-023 While pending=1 and en=0, a new request SHALL overwrite the held target (newest wins; jump-over-branch priority applies within the cycle).
REQ-024 When pending=1 and en=1, pc SHALL load the held target; a jump/branch in that same cycle SHALL take priority over the held target; pending SHALL clear next cycle.
REQ-025 Targets SHALL be computed from pc_seq at the cycle the request is presented, not when applied.
REQ-026 flush SHALL be 1 for exactly one cycle following any cycle in which pc loaded a redirect target (direct or from pending), else 0.
REQ-027 Latency: redirect presented with en=1 SHALL appear on pc one clock later.

Reset
REQ-028 With reset=1 at a rising edge, pc SHALL become 0, pending 0, held target 0, flush 0, regardless of en/jump/branch.
REQ-029 Reset mid-stall SHALL discard any pending redirect; first post-reset cycle with en=1 SHALL yield pc=PC_STEP.

Structure
REQ-030 Mode encodings (JMP_MODE values) and the default widths SHALL live in the shared processor package.
REQ-031 Target formation SHALL be one sub-module, imm_extend, parametrised by input width, output width and mode (zero/sign), instantiated for jump and branch paths.
REQ-032 State SHALL be exactly: pc register, pending flag, held target register, flush flag.

Verification
REQ-033 Reset then en=1 for 3 cycles -> pc = 0, 1, 2, 3; flush=0 throughout.
REQ-034 pc=0x10, en=1, jump=1, jaddr=5'h1F, JMP_MODE=0 -> next pc=0x1F, flush=1 one cycle.
REQ-035 pc=0x10, en=1, branch=1, imm=5'h1E (-2) -> next pc=0x0F; same cycle jump=1, jaddr=3 -> pc=0x03 instead.
REQ-036 pc=0x20, en=0, branch=1, imm=4 -> pc holds 0x20, pending=1; en=1 next -> pc=0x25, pending=0, flush=1.
REQ-037 pc=0xFF, en=1, no redirect -> pc=0x00; JMP_MODE=1, pc=0xE0, jaddr=5'h03 -> pc=0xE3.
REQ-038 pending=1 then reset=1 -> pc=0, pending=0; en=1 -> pc=0x01.
